muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 30 +++
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the sequential RISC-V M-extension unit.
//   i_valid/o_ready  : request handshake, accepted when both high
//   i_funct3         : M-extension op select
//   i_in_a/i_in_b    : multiplicand/dividend, multiplier/divisor
//   i_kill           : abort the operation in flight
//   o_valid/o_result : one-cycle result strobe and the held result
//   o_busy           : a multiply or divide is iterating
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_in_a;
  logic [XLEN-1:0] i_in_b;
  logic            i_kill;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_funct3, i_in_a, i_in_b, i_kill,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_funct3, i_in_a, i_in_b, i_kill,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential multiplier/divider for the RISC-V M extension.
// Multiply is shift-add retiring MUL_STEP multiplier bits per clock; divide is
// restoring division retiring DIV_STEP quotient bits per clock. Both work on
// magnitudes and apply the sign on the final edge.
//   i_clk_n : clock, rising edge active
//   i_rst_n : synchronous active-low reset
//   bus     : request/response bundle (muldiv_seq_if.slave)
module muldiv_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2,
  parameter int DIV_STEP = 1
) (
  input logic          i_clk_n,
  input logic          i_rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] K_MUL = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] K_DIV = CW'(XLEN / DIV_STEP);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_next;

  // acc holds {high, low}: for multiply {partial product, remaining multiplier},
  // for divide {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;      // |multiplicand| or |divisor|
  logic [XLEN-1:0]   a_raw;     // untouched dividend for the special cases
  logic [XLEN-1:0]   result;
  logic [2:0]        f3;
  logic              res_neg, div_zero, div_ovf, vld;
  logic [CW-1:0]     cnt;

  function automatic logic [2*XLEN-1:0] neg_wide(logic [2*XLEN-1:0] v, logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_narrow(logic [XLEN-1:0] v, logic n);
    return n ? -v : v;
  endfunction

  // Capture-time decode
  logic            sgn_a, sgn_b, neg_a, neg_b, in_div, in_zero, in_ovf, in_res_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            accept, fin;

  always_comb begin
    sgn_a      = bus.i_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b      = bus.i_funct3 inside {3'b001, 3'b100, 3'b110};
    neg_a      = sgn_a & bus.i_in_a[XLEN-1];
    neg_b      = sgn_b & bus.i_in_b[XLEN-1];
    mag_a      = neg_narrow(bus.i_in_a, neg_a);
    mag_b      = neg_narrow(bus.i_in_b, neg_b);
    in_div     = bus.i_funct3[2];
    in_zero    = in_div && (bus.i_in_b == '0);
    in_ovf     = in_div && !bus.i_funct3[0] && (bus.i_in_a == MIN_NEG) && (bus.i_in_b == '1);
    // Remainder follows the dividend; product and quotient follow both operands.
    in_res_neg = (bus.i_funct3[2] && bus.i_funct3[1]) ? neg_a : (neg_a ^ neg_b);
  end

  assign accept = (state == IDLE) && bus.i_valid && !bus.i_kill;
  assign fin    = !bus.i_kill && (((state == MUL) && (cnt == K_MUL)) ||
                                  ((state == DIV) && (cnt == K_DIV)));

  // Shift-add step: add opnd * low multiplier bits into the high half, shift right.
  logic [XLEN+MUL_STEP-1:0] pp, mul_sum;
  logic [2*XLEN-1:0]        mul_next;

  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (acc[j]) pp = pp + ({{MUL_STEP{1'b0}}, opnd} << j);
    end
    mul_sum  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
    mul_next = {mul_sum, acc[XLEN-1:MUL_STEP]};
  end

  // Restoring step: shift the next dividend bit in, keep the difference if it
  // did not borrow. A restored remainder is below the divisor, so its top bit
  // is always zero and dropping shifted[XLEN] is safe.
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    div_next = acc;
    shifted  = '0;
    diff     = '0;
    for (int s = 0; s < DIV_STEP; s++) begin
      shifted = {div_next[2*XLEN-1:XLEN], div_next[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[XLEN]) div_next = {diff[XLEN-1:0], div_next[XLEN-2:0], 1'b1};
      else             div_next = {shifted[XLEN-1:0], div_next[XLEN-2:0], 1'b0};
    end
  end

  // Final sign correction and result select
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   fin_val;

  always_comb begin
    prod_c  = neg_wide(acc, res_neg);
    fin_val = '0;
    if (state == MUL) begin
      fin_val = (f3[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end else if (div_zero) begin
      fin_val = f3[1] ? a_raw : '1;
    end else if (div_ovf) begin
      fin_val = f3[1] ? '0 : a_raw;
    end else begin
      fin_val = f3[1] ? neg_narrow(acc[2*XLEN-1:XLEN], res_neg)
                      : neg_narrow(acc[XLEN-1:0], res_neg);
    end
  end

  // Control state register
  always_ff @(posedge i_clk_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bus.i_funct3[2] ? DIV : MUL;
      MUL:     if (bus.i_kill) state_next = IDLE;
               else if (cnt == K_MUL) state_next = DONE;
      DIV:     if (bus.i_kill) state_next = IDLE;
               else if (cnt == K_DIV) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Special divides preload the step counter as already finished so
  // the next edge goes straight to DONE.
  always_ff @(posedge i_clk_n) begin
    if (!i_rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      f3       <= '0;
      res_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      vld      <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (accept) begin
        acc      <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
        opnd     <= in_div ? mag_b : mag_a;
        a_raw    <= bus.i_in_a;
        f3       <= bus.i_funct3;
        res_neg  <= in_res_neg;
        div_zero <= in_zero;
        div_ovf  <= in_ovf;
        cnt      <= (in_zero || in_ovf) ? K_DIV : '0;
      end else if (state == MUL && !bus.i_kill && cnt != K_MUL) begin
        acc <= mul_next;
        cnt <= cnt + CW'(1);
      end else if (state == DIV && !bus.i_kill && cnt != K_DIV) begin
        acc <= div_next;
        cnt <= cnt + CW'(1);
      end
      if (fin) begin
        result <= fin_val;
        vld    <= 1'b1;
      end
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_busy   = (state == MUL) || (state == DIV);
  assign bus.o_valid  = vld;
  assign bus.o_result = result;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus();

  muldiv_seq #(.XLEN(XLEN), .MUL_STEP(2), .DIV_STEP(1)) dut (
    .i_clk_n (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_res(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (!f3[2]) return 17;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Starts #1 after a rising edge; ends #1 after an edge with the unit idle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bus.i_valid  = 1'b1;
    bus.i_funct3 = f3;
    bus.i_in_a   = a;
    bus.i_in_b   = b;
    @(posedge clk); #1;
    bus.i_valid  = 1'b0;
    bus.i_in_a   = $urandom;   // operands must be ignored after accept
    bus.i_in_b   = $urandom;
    bus.i_funct3 = 3'($urandom);
    lat = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (bus.o_valid) begin lat = n; break; end
    end
    if (lat == 0) begin
      chk({name, " timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " result"}, {32'b0, bus.o_result}, {32'b0, exp_res});
      @(posedge clk); #1;
      chk({name, " strobe one cycle"}, {63'b0, bus.o_valid}, 64'd0);
      chk({name, " hold"}, {32'b0, bus.o_result}, {32'b0, exp_res});
    end
  endtask

  vec_t tbl[10];
  logic [31:0] corner[5];

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          saw_valid;

    tbl[0] = '{"MULH -1*2",   3'b001, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFF, 17};
    tbl[1] = '{"MUL -1*2",    3'b000, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFE, 17};
    tbl[2] = '{"DIV -7/2",    3'b100, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 33};
    tbl[3] = '{"REM -7%2",    3'b110, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 33};
    tbl[4] = '{"REMU 7%2",    3'b111, 32'h7,         32'h2,          32'h1,         33};
    tbl[5] = '{"DIVU 5/0",    3'b101, 32'h5,         32'h0,          32'hFFFF_FFFF, 1};
    tbl[6] = '{"REMU 5%0",    3'b111, 32'h5,         32'h0,          32'h5,         1};
    tbl[7] = '{"DIV ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1};
    tbl[8] = '{"REM ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         1};
    tbl[9] = '{"MULHSU -1*3", 3'b010, 32'hFFFF_FFFF, 32'h3,          32'hFFFF_FFFF, 17};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_kill = 1'b0; bus.i_funct3 = '0;
    bus.i_in_a = '0; bus.i_in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready",  {63'b0, bus.o_ready},  64'd1);
    chk("reset busy",   {63'b0, bus.o_busy},   64'd0);
    chk("reset valid",  {63'b0, bus.o_valid},  64'd0);
    chk("reset result", {32'b0, bus.o_result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i].name, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // Kill a divide mid-flight; the previous MUL result must survive.
    run_op("MUL 6*7", 3'b000, 32'd6, 32'd7, 32'd42, 17);
    bus.i_valid = 1'b1; bus.i_funct3 = 3'b100; bus.i_in_a = 32'd1000; bus.i_in_b = 32'd3;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy before kill", {63'b0, bus.o_busy}, 64'd1);
    bus.i_kill = 1'b1;
    @(posedge clk); #1;
    bus.i_kill = 1'b0;
    chk("kill busy",  {63'b0, bus.o_busy},  64'd0);
    chk("kill ready", {63'b0, bus.o_ready}, 64'd1);
    saw_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_valid) saw_valid++;
    end
    chk("kill no valid", 64'(saw_valid), 64'd0);
    chk("kill result kept", {32'b0, bus.o_result}, 64'd42);
    run_op("MULHU after kill", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17);

    // Reset in the middle of a multiply.
    bus.i_valid = 1'b1; bus.i_funct3 = 3'b000; bus.i_in_a = 32'd9; bus.i_in_b = 32'd9;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst mid result", {32'b0, bus.o_result}, 64'd0);
    chk("rst mid valid",  {63'b0, bus.o_valid},  64'd0);
    chk("rst mid ready",  {63'b0, bus.o_ready},  64'd1);
    saw_valid = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.o_valid) saw_valid++;
    end
    chk("rst mid no valid", 64'(saw_valid), 64'd0);

    // Request with kill asserted in IDLE is not accepted.
    bus.i_valid = 1'b1; bus.i_kill = 1'b1; bus.i_funct3 = 3'b000;
    @(posedge clk); #1;
    chk("kill blocks accept busy",  {63'b0, bus.o_busy},  64'd0);
    chk("kill blocks accept ready", {63'b0, bus.o_ready}, 64'd1);
    bus.i_valid = 1'b0; bus.i_kill = 1'b0;
    @(posedge clk); #1;

    // Randomised operations against the reference model.
    for (int r = 0; r < 60; r++) begin
      rf3 = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", r, rf3, ra, rb), rf3, ra, rb,
             ref_res(rf3, ra, rb), ref_lat(rf3, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
